instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Instruction fetch front end for the 8-bit core.
- Owns a fetch pointer and issues read requests to instruction memory over a req/ack handshake.
- Buffers returned words, each tagged with its address, in a small first-word-fall-through FIFO.
- Presents words to decode with valid/ready; a flush input redirects fetch on taken branches and jumps.

Parameters:
- ADDR_W, 8, fetch address width; pointer wraps modulo 2^ADDR_W.
- DATA_W, 16, instruction word width.
- FIFO_DEPTH, 4, buffer entries; power of two, at least 2.
- RESET_ADDR, 0, fetch pointer value after reset.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- areset  input  1  reset, synchronous, active-high.
- flush  input  1  redirect request; highest priority after reset.
- flush_addr  input  ADDR_W  new fetch address, sampled when flush=1.
- mem_req  output  1  read request to instruction memory.
- mem_addr  output  ADDR_W  read address; stable while mem_req=1.
- mem_ack  input  1  read completes this cycle; mem_rdata valid.
- mem_rdata  input  DATA_W  returned instruction word.
- instr_valid  output  1  FIFO head holds a word.
- instr  output  DATA_W  FIFO head word.
- instr_pc  output  ADDR_W  address of FIFO head word.
- instr_ready  input  1  decode accepts head this cycle.

Behaviour:
- Reset values: state=IDLE, mem_req=0, mem_addr=0, fetch_ptr=RESET_ADDR, FIFO count=0, instr_valid=0. Reset mid-transaction abandons it; memory must tolerate a dropped request.
- Internal fetch_ptr is ADDR_W bits; incrementing FIFO_DEPTH-1... no, 2^ADDR_W-1 yields 0 (no overflow flag).
- space = FIFO_DEPTH - count. A new request issues only when space >= 1. Only one request is outstanding at a time.
- State IDLE:
  - If no flush and space >= 1: mem_req<=1, mem_addr<=fetch_ptr, go to WAIT.
  - Otherwise stay in IDLE with mem_req=0.
- State WAIT:
  - mem_req and mem_addr are held.
  - On mem_ack: push {mem_addr, mem_rdata}, fetch_ptr<=fetch_ptr+1, mem_req<=0, go to IDLE.
  - Minimum issue interval is 2 cycles.
- State DISCARD:
  - Entered from WAIT on flush without a same-cycle ack.
  - mem_req stays 1 and mem_addr is held.
  - On mem_ack: data dropped, mem_req<=0, go to IDLE.
  - Further flushes in DISCARD update fetch_ptr only.
- mem_ack is ignored whenever mem_req=0.
- Flush, in any state:
  - FIFO cleared (count<=0) and fetch_ptr<=flush_addr.
  - instr_valid=0 from the next cycle.
  - IDLE: no request in the flush cycle.
  - WAIT without ack: go to DISCARD.
  - WAIT with ack in the same cycle: data dropped, no push, go to IDLE.
  - A pop in the flush cycle is still accepted by decode; flush then clears the remaining entries.
- Pop: instr_valid & instr_ready removes the head. Asserting instr_ready while instr_valid=0 has no effect.
- Simultaneous push and pop: count unchanged. Pushing to a full FIFO cannot occur because of the space check.
- Output path:
  - instr and instr_pc are driven combinationally from the head entry.
  - instr_valid = (count != 0).
  - A pushed word is visible the cycle after mem_ack (1-cycle ack-to-valid latency).

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - Adds output port fetch_stall_cnt (16 bits, reset 0).
  - It increments, saturating at 0xFFFF, every cycle that instr_ready=1 and instr_valid=0.
  - It clears on areset only; flush does not clear it.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset with RESET_ADDR=0x10, areset high 2 cycles, then ack 1 cycle after each request, instr_ready=1 -> mem_addr sequence 0x10,0x11,0x12; instr_pc matches each; instr_valid=0 during reset.
- instr_ready=0, zero-delay acks -> exactly 4 words buffered; mem_req stays 0 afterward. Raise instr_ready -> 4 pops in order, then fetch resumes at 0x14.
- Flush (flush_addr=0x80) in WAIT, ack 3 cycles later -> DISCARD; acked word not pushed; next request mem_addr=0x80; instr_valid=0 until the 0x80 word arrives.
- Flush coincident with mem_ack -> word dropped, FIFO empty, next mem_addr=flush_addr.
- Start at 0xFE with continuous acks -> addresses 0xFE,0xFF,0x00,0x01; instr_pc wraps correctly.
- areset asserted mid-WAIT with 2 words buffered -> next cycle mem_req=0, instr_valid=0, fetch_ptr=RESET_ADDR. With FETCH_PERF_EN, 5 starved ready cycles -> fetch_stall_cnt=5.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_unit_if
// Brief   : Instruction-memory request bus plus decode-side valid/ready port.
// Rev     : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_unit
// Brief   : Fetch pointer, single-outstanding memory reads and a tagged FWFT
//           buffer feeding decode; flush redirects fetch.
//           Optional macro FETCH_PERF_EN adds the fetch_stall_cnt output.
// Rev     : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int RESET_ADDR = 0
) (
  input  logic              CLK,
  input  logic              areset,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_addr,
  instr_fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       fetch_stall_cnt
`endif
);

  localparam int                  c_idx_w      = $clog2(FIFO_DEPTH);
  localparam int                  c_cnt_w      = c_idx_w + 1;
  localparam logic [c_cnt_w-1:0]  c_full       = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_cnt_w-1:0]  c_cnt_one    = c_cnt_w'(1);
  localparam logic [c_idx_w-1:0]  c_idx_one    = c_idx_w'(1);
  localparam logic [ADDR_W-1:0]   c_ptr_one    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0]   c_reset_addr = ADDR_W'(RESET_ADDR);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_mem_req, w_mem_req_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [ADDR_W-1:0]   r_fetch_ptr, w_fetch_ptr_nxt;
  logic                w_push, w_clear, w_pop, w_ack, w_has_space, w_instr_valid;

  logic [DATA_W-1:0]   r_data [FIFO_DEPTH];
  logic [ADDR_W-1:0]   r_pc   [FIFO_DEPTH];
  logic [c_idx_w-1:0]  r_rd_idx, r_wr_idx;
  logic [c_cnt_w-1:0]  r_count;

  assign w_ack         = r_mem_req & bus.mem_ack;
  assign w_has_space   = (r_count != c_full);
  assign w_instr_valid = (r_count != '0);
  assign w_pop         = w_instr_valid & bus.instr_ready;

  always_ff @(posedge CLK) begin
    if (areset) begin
      r_state     <= ST_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_fetch_ptr <= c_reset_addr;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_fetch_ptr <= w_fetch_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_mem_req_nxt   = r_mem_req;
    w_mem_addr_nxt  = r_mem_addr;
    w_fetch_ptr_nxt = r_fetch_ptr;
    w_push          = 1'b0;
    w_clear         = 1'b0;
    if (flush) begin
      w_clear         = 1'b1;
      w_fetch_ptr_nxt = flush_addr;
    end
    case (r_state)
      ST_IDLE: begin
        if (!flush && w_has_space) begin
          w_mem_req_nxt  = 1'b1;
          w_mem_addr_nxt = r_fetch_ptr;
          w_state_nxt    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // An ack arriving with a flush completes the bus cycle but its word is stale.
        if (w_ack) begin
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = ST_IDLE;
          if (!flush) begin
            w_push          = 1'b1;
            w_fetch_ptr_nxt = r_fetch_ptr + c_ptr_one;
          end
        end else if (flush) begin
          w_state_nxt = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (w_ack) begin
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = ST_IDLE;
        end
      end
      default: begin
        w_mem_req_nxt = 1'b0;
        w_state_nxt   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (areset || w_clear) begin
      r_count  <= '0;
      r_rd_idx <= '0;
      r_wr_idx <= '0;
    end else begin
      if (w_push) r_wr_idx <= r_wr_idx + c_idx_one;
      if (w_pop)  r_rd_idx <= r_rd_idx + c_idx_one;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entries are tagged with the request address so decode sees each word's PC.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_data[r_wr_idx] <= bus.mem_rdata;
      r_pc[r_wr_idx]   <= r_mem_addr;
    end
  end

  assign bus.mem_req     = r_mem_req;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.instr_valid = w_instr_valid;
  assign bus.instr       = r_data[r_rd_idx];
  assign bus.instr_pc    = r_pc[r_rd_idx];

`ifdef FETCH_PERF_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge CLK) begin
    if (areset) begin
      r_stall_cnt <= '0;
    end else if (bus.instr_ready && !w_instr_valid && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign fetch_stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
